klp_result_checker: RTL and testbench
=====================================

Name: klp_result_checker

Overview:
- Parametrised, synthesizable self-checking scoreboard for KLP32 cores.
- Replaces per-cycle hand-timed check tasks. Expected results are queued ahead of time, and each observed retirement event (e.g. RegWEn with writeBack) is compared in order against the queue.
- Keeps pass/fail/unexpected counters, a sticky mismatch flag, first-failure capture and a no-progress timeout.
- Instantiated beside the core in benches or on FPGA; taps the core's debug outputs.

Parameters:
- DATA_W, 32, width of compared data.
- DEPTH, 16, expected-queue entries; power of two, >= 2.
- TIMEOUT, 64, cycles a non-empty queue may wait without act_valid before the head entry is retired as a failure; 0 disables the timeout.
- CNT_W, 16, width of all event counters; counters saturate.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- exp_valid, input, 1: push request for an expected entry.
- exp_data, input, DATA_W: expected value.
- exp_mask, input, DATA_W: compare mask; 1 = bit compared.
- exp_ready, output, 1: queue can accept; equals !full.
- act_valid, input, 1: observed event this cycle.
- act_data, input, DATA_W: observed value.
- level, output, $clog2(DEPTH)+1: queue occupancy.
- pass_count, output, CNT_W: matched events.
- fail_count, output, CNT_W: mismatches plus timeouts.
- unexp_count, output, CNT_W: act_valid events seen with the queue empty.
- mismatch, output, 1: sticky; set on the first failure of any kind.
- timeout, output, 1: sticky; set when any timeout fires.
- first_seq, output, CNT_W: event index (0-based, counts every act_valid) of the first failure.
- first_exp, output, DATA_W: expected value at the first failure.
- first_act, output, DATA_W: actual value at the first failure; 0 if the failure was a timeout.
- result_valid, output, 1: one-cycle pulse one cycle after each compare or timeout.
- result_pass, output, 1: qualifies result_valid.

Behaviour:
- Reset (synchronous, active-high):
  - Queue emptied; level=0.
  - All counters, mismatch, timeout, first_*, result_valid and result_pass are 0.
  - Timeout counter cleared.
  - Reset asserted mid-operation discards queued entries and any in-flight result; the result_valid pulse is suppressed.
- Push:
  - Accepted when exp_valid && exp_ready.
  - A push while full is ignored, is not counted, and the queue contents are unchanged.
- Compare:
  - When act_valid and level>0, the head is popped in the same cycle.
  - pass = ((act_data ^ head.data) & head.mask) == 0.
  - The result is registered: result_valid/result_pass and counter updates are visible one cycle later.
- Empty queue:
  - act_valid with level==0 increments unexp_count and sets mismatch.
  - It counts as a failure for first_* capture, with first_exp=0.
  - It does not affect fail_count or result_valid.
- Simultaneous push and pop:
  - Both take effect; level is unchanged.
  - When the queue is full, a same-cycle pop does not enable the push, because exp_ready depends only on full.
  - When the queue is empty, act_valid is unexpected even if a push occurs in the same cycle; the pushed entry stays queued.
- Timeout:
  - The counter increments each cycle with level>0 and !act_valid.
  - It clears on act_valid or when level==0.
  - On reaching TIMEOUT, the head is popped, fail_count increments, timeout and mismatch are set, and result_valid pulses with result_pass=0.
  - The counter then restarts for the next head.
- first_seq/first_exp/first_act are loaded only on the event that first sets mismatch, and are frozen afterwards.
- Counters saturate at all-ones. The event index used for first_seq also saturates.
- Pointers wrap modulo DEPTH; full is determined by level==DEPTH.

Test Plan:
- Push 5,4,1 (mask all-ones); act 5,4,1 on consecutive cycles -> pass_count=3, fail_count=0, mismatch=0, level=0, three result_pass pulses each one cycle after act.
- Push 8, then act 2 -> one cycle later result_valid=1, result_pass=0; fail_count=1, mismatch=1, first_seq=0, first_exp=8, first_act=2. A later failure leaves first_* unchanged.
- Push h'4C000 with mask h'FFFFF000, then act h'4C123 -> pass.
- act_valid with the queue empty -> unexp_count=1, mismatch=1, fail_count=0.
- TIMEOUT=4: push 7, hold act_valid low -> on the 4th waiting cycle the entry is popped; timeout=1, fail_count=1, first_act=0.
- Fill 16 entries -> exp_ready=0 and a 17th push is ignored. Push+act in the same cycle at level=15 -> level stays 15. Drain 16 entries with wrap -> all pass. Assert reset mid-drain -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/klp_result_checker.sv
// klp_result_checker: in-order scoreboard that compares observed retirement
// events from a KLP32 core against a queue of expected (data, mask) entries.
// Tracks pass/fail/unexpected counts, captures the first failure and retires
// a stalled head entry as a failure after a configurable no-progress timeout.
module klp_result_checker #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exp_valid,
  input  logic [DATA_W-1:0]       exp_data,
  input  logic [DATA_W-1:0]       exp_mask,
  output logic                    exp_ready,
  input  logic                    act_valid,
  input  logic [DATA_W-1:0]       act_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        pass_count,
  output logic [CNT_W-1:0]        fail_count,
  output logic [CNT_W-1:0]        unexp_count,
  output logic                    mismatch,
  output logic                    timeout,
  output logic [CNT_W-1:0]        first_seq,
  output logic [DATA_W-1:0]       first_exp,
  output logic [DATA_W-1:0]       first_act,
  output logic                    result_valid,
  output logic                    result_pass
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  // Wait counter value on the cycle that retires the head: the TIMEOUT-th idle cycle.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Saturating increment shared by every event counter and the event index.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] memData [DEPTH];
  logic [DATA_W-1:0] memMask [DEPTH];
  logic [AW-1:0]     rdPtr;
  logic [AW-1:0]     wrPtr;
  logic [TW-1:0]     waitCnt;
  logic [CNT_W-1:0]  seqCnt;

  logic              full_p0;
  logic              empty_p0;
  logic              pushEn_p0;
  logic              cmpEn_p0;
  logic              unexpEn_p0;
  logic              cmpPass_p0;
  logic              toFire_p0;
  logic              popEn_p0;
  logic              failEn_p0;
  logic              anyFail_p0;
  logic [DATA_W-1:0] headData_p0;
  logic [DATA_W-1:0] headMask_p0;

  // Stage p0: decode this cycle's push, compare, unexpected and timeout events.
  assign full_p0     = (level == LW'(DEPTH));
  assign empty_p0    = (level == '0);
  assign exp_ready   = !full_p0;
  assign pushEn_p0   = exp_valid && !full_p0;
  assign headData_p0 = memData[rdPtr];
  assign headMask_p0 = memMask[rdPtr];
  assign cmpEn_p0    = act_valid && !empty_p0;
  assign unexpEn_p0  = act_valid && empty_p0;
  assign cmpPass_p0  = (((act_data ^ headData_p0) & headMask_p0) == '0);
  assign toFire_p0   = TO_EN && !empty_p0 && !act_valid && (waitCnt == TO_LAST);
  assign popEn_p0    = cmpEn_p0 || toFire_p0;
  assign failEn_p0   = (cmpEn_p0 && !cmpPass_p0) || toFire_p0;
  assign anyFail_p0  = failEn_p0 || unexpEn_p0;

  // Expected-entry storage; contents are don't-care outside the live window.
  always_ff @(posedge clk) begin
    if (pushEn_p0) begin
      memData[wrPtr] <= exp_data;
      memMask[wrPtr] <= exp_mask;
    end
  end

  // Stage p0 -> p1: queue bookkeeping, counters, first-failure capture and result pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr        <= '0;
      wrPtr        <= '0;
      level        <= '0;
      waitCnt      <= '0;
      seqCnt       <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
      unexp_count  <= '0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
      first_seq    <= '0;
      first_exp    <= '0;
      first_act    <= '0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
    end else begin
      if (pushEn_p0) wrPtr <= wrPtr + AW'(1);
      if (popEn_p0)  rdPtr <= rdPtr + AW'(1);
      if (pushEn_p0 && !popEn_p0)      level <= level + LW'(1);
      else if (!pushEn_p0 && popEn_p0) level <= level - LW'(1);

      if (empty_p0 || act_valid || toFire_p0) waitCnt <= '0;
      else                                    waitCnt <= waitCnt + TW'(1);

      if (act_valid)                 seqCnt      <= satInc(seqCnt);
      if (cmpEn_p0 && cmpPass_p0)    pass_count  <= satInc(pass_count);
      if (failEn_p0)                 fail_count  <= satInc(fail_count);
      if (unexpEn_p0)                unexp_count <= satInc(unexp_count);
      if (toFire_p0)                 timeout     <= 1'b1;
      if (anyFail_p0)                mismatch    <= 1'b1;

      if (anyFail_p0 && !mismatch) begin
        first_seq <= seqCnt;
        first_exp <= unexpEn_p0 ? '0 : headData_p0;
        first_act <= toFire_p0 ? '0 : act_data;
      end

      result_valid <= popEn_p0;
      result_pass  <= cmpEn_p0 && cmpPass_p0;
    end
  end

endmodule

// File: tb/tb_klp_result_checker.sv
// tb_klp_result_checker: directed scenarios followed by a randomized run,
// every cycle compared against a queue-based reference scoreboard.
module tb_klp_result_checker;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TO    = 20;
  localparam int CW    = 6;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] exp_mask;
  logic          exp_ready;
  logic          act_valid;
  logic [DW-1:0] act_data;
  logic [4:0]    level;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic [CW-1:0] unexp_count;
  logic          mismatch;
  logic          timeout;
  logic [CW-1:0] first_seq;
  logic [DW-1:0] first_exp;
  logic [DW-1:0] first_act;
  logic          result_valid;
  logic          result_pass;

  klp_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_mask(exp_mask), .exp_ready(exp_ready),
    .act_valid(act_valid), .act_data(act_data), .level(level),
    .pass_count(pass_count), .fail_count(fail_count), .unexp_count(unexp_count),
    .mismatch(mismatch), .timeout(timeout), .first_seq(first_seq),
    .first_exp(first_exp), .first_act(first_act),
    .result_valid(result_valid), .result_pass(result_pass)
  );

  always #5 clk = ~clk;

  // Reference scoreboard state
  typedef struct { logic [31:0] d; logic [31:0] m; } ent_t;
  ent_t mq[$];
  int          mPass, mFail, mUnexp, mSeq, mWait, mFseq;
  bit          mMis, mTo, mRv, mRp;
  logic [31:0] mFexp, mFact;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) begin
      nPass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic modelReset();
    mq.delete();
    mPass = 0; mFail = 0; mUnexp = 0; mSeq = 0; mWait = 0; mFseq = 0;
    mMis = 0; mTo = 0; mRv = 0; mRp = 0; mFexp = 0; mFact = 0;
  endtask

  task automatic noteFail(input logic [31:0] e, input logic [31:0] a);
    if (!mMis) begin
      mFseq = mSeq; mFexp = e; mFact = a;
    end
    mMis = 1;
  endtask

  // One clock of scoreboard behaviour, written from the queue-level rules.
  task automatic modelStep(input bit ev, input logic [31:0] ed, input logic [31:0] em,
                           input bit av, input logic [31:0] ad);
    bit   canPush;
    ent_t h;
    canPush = ev && (mq.size() < DEPTH);
    mRv = 0; mRp = 0;
    if (av) begin
      if (mq.size() == 0) begin
        mUnexp = sat(mUnexp);
        noteFail(32'h0, ad);
      end else begin
        h = mq.pop_front();
        mRv = 1;
        if (((ad ^ h.d) & h.m) == 0) begin
          mRp = 1; mPass = sat(mPass);
        end else begin
          mFail = sat(mFail);
          noteFail(h.d, ad);
        end
      end
      mWait = 0;
      mSeq  = sat(mSeq);
    end else if (mq.size() > 0) begin
      mWait++;
      if (mWait == TO) begin
        h = mq.pop_front();
        mRv = 1; mTo = 1; mFail = sat(mFail);
        noteFail(h.d, 32'h0);
        mWait = 0;
      end
    end else begin
      mWait = 0;
    end
    if (canPush) mq.push_back('{d: ed, m: em});
  endtask

  task automatic checkAll();
    check("level", 32'(level), 32'(mq.size()));
    check("exp_ready", 32'(exp_ready), 32'(mq.size() < DEPTH));
    check("pass_count", 32'(pass_count), 32'(mPass));
    check("fail_count", 32'(fail_count), 32'(mFail));
    check("unexp_count", 32'(unexp_count), 32'(mUnexp));
    check("mismatch", 32'(mismatch), 32'(mMis));
    check("timeout", 32'(timeout), 32'(mTo));
    check("first_seq", 32'(first_seq), 32'(mFseq));
    check("first_exp", first_exp, mFexp);
    check("first_act", first_act, mFact);
    check("result_valid", 32'(result_valid), 32'(mRv));
    check("result_pass", 32'(result_pass), 32'(mRp));
  endtask

  task automatic cycle(input bit ev, input logic [31:0] ed, input logic [31:0] em,
                       input bit av, input logic [31:0] ad);
    exp_valid = ev; exp_data = ed; exp_mask = em; act_valid = av; act_data = ad;
    modelStep(ev, ed, em, av, ad);
    @(posedge clk); #1;
    checkAll();
  endtask

  // Reset cycle; av lets an act event arrive together with reset to be discarded.
  task automatic doReset(input bit av);
    reset = 1; exp_valid = 0; act_valid = av; act_data = $urandom;
    modelReset();
    @(posedge clk); #1;
    reset = 0; act_valid = 0;
    checkAll();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          quiet;
    bit          ev, av;
    logic [31:0] ed, em, ad;

    reset = 1; exp_valid = 0; exp_data = 0; exp_mask = 0; act_valid = 0; act_data = 0;
    doReset(0);
    check("rst_level", 32'(level), 0);
    check("rst_ready", 32'(exp_ready), 1);

    // In-order passes, each result one cycle after its act
    cycle(1, 5, '1, 0, 0);
    cycle(1, 4, '1, 0, 0);
    cycle(1, 1, '1, 0, 0);
    cycle(0, 0, 0, 1, 5);
    check("p1_rv", 32'(result_valid), 1);
    check("p1_rp", 32'(result_pass), 1);
    cycle(0, 0, 0, 1, 4);
    cycle(0, 0, 0, 1, 1);
    check("p3_pass", 32'(pass_count), 3);
    check("p3_fail", 32'(fail_count), 0);
    check("p3_mis", 32'(mismatch), 0);
    check("p3_level", 32'(level), 0);

    // Mismatch and first-failure freeze
    doReset(0);
    cycle(1, 8, '1, 0, 0);
    cycle(0, 0, 0, 1, 2);
    check("mm_rv", 32'(result_valid), 1);
    check("mm_rp", 32'(result_pass), 0);
    check("mm_fail", 32'(fail_count), 1);
    check("mm_mis", 32'(mismatch), 1);
    check("mm_fseq", 32'(first_seq), 0);
    check("mm_fexp", first_exp, 8);
    check("mm_fact", first_act, 2);
    cycle(1, 9, '1, 0, 0);
    cycle(0, 0, 0, 1, 3);
    check("mm2_fail", 32'(fail_count), 2);
    check("mm2_fexp", first_exp, 8);
    check("mm2_fact", first_act, 2);

    // Masked compare ignores low bits
    doReset(0);
    cycle(1, 32'h0004C000, 32'hFFFFF000, 0, 0);
    cycle(0, 0, 0, 1, 32'h0004C123);
    check("mask_rp", 32'(result_pass), 1);
    check("mask_fail", 32'(fail_count), 0);

    // act_valid with empty queue, with a simultaneous push that stays queued
    doReset(0);
    cycle(1, 32'h33, '1, 1, 32'h77);
    check("ux_unexp", 32'(unexp_count), 1);
    check("ux_mis", 32'(mismatch), 1);
    check("ux_fail", 32'(fail_count), 0);
    check("ux_rv", 32'(result_valid), 0);
    check("ux_fexp", first_exp, 0);
    check("ux_fact", first_act, 32'h77);
    check("ux_level", 32'(level), 1);

    // No-progress timeout retires the head on the TO-th idle cycle
    doReset(0);
    cycle(1, 7, '1, 0, 0);
    for (int k = 1; k < TO; k++) cycle(0, 0, 0, 0, 0);
    check("to_pre_level", 32'(level), 1);
    check("to_pre_flag", 32'(timeout), 0);
    cycle(0, 0, 0, 0, 0);
    check("to_level", 32'(level), 0);
    check("to_flag", 32'(timeout), 1);
    check("to_fail", 32'(fail_count), 1);
    check("to_rv", 32'(result_valid), 1);
    check("to_rp", 32'(result_pass), 0);
    check("to_fexp", first_exp, 7);
    check("to_fact", first_act, 0);
    cycle(0, 0, 0, 0, 0);
    check("to_pulse_end", 32'(result_valid), 0);

    // Full queue, ignored push, push+pop at 15, wrapped drain, reset mid-drain
    doReset(0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h100 + i, '1, 0, 0);
    check("full_ready", 32'(exp_ready), 0);
    check("full_level", 32'(level), 16);
    cycle(1, 32'hDEAD, '1, 0, 0);
    check("full_ignored", 32'(level), 16);
    cycle(0, 0, 0, 1, 32'h100);
    cycle(1, 32'h200, '1, 1, 32'h101);
    check("pp_level", 32'(level), 15);
    cycle(1, 32'h201, '1, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 0, 0, 1, (i < 14) ? 32'h102 + i : 32'h200 + i - 14);
    check("drain_pass", 32'(pass_count), 18);
    check("drain_fail", 32'(fail_count), 0);
    check("drain_level", 32'(level), 0);
    for (int i = 0; i < 6; i++) cycle(1, 32'h300 + i, '1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h300 + i);
    doReset(1);
    check("rst_mid_level", 32'(level), 0);
    check("rst_mid_pass", 32'(pass_count), 0);
    check("rst_mid_rv", 32'(result_valid), 0);
    check("rst_mid_seq", 32'(first_seq), 0);

    // Randomized traffic with busy/quiet phases and occasional resets
    quiet = 0;
    for (int i = 0; i < 700; i++) begin
      if (i % 70 == 0) quiet = !quiet;
      ev = ($urandom_range(0, 99) < (quiet ? 20 : 45));
      ed = $urandom & 32'hFF;
      em = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
      av = ($urandom_range(0, 99) < (quiet ? 4 : 50));
      if (av && mq.size() > 0 && $urandom_range(0, 3) != 0)
        ad = mq[0].d ^ ($urandom & ~mq[0].m);
      else
        ad = $urandom & 32'hFF;
      if ($urandom_range(0, 249) == 0) doReset(av);
      else cycle(ev, ed, em, av, ad);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
